// File: rtl/multicycle_control.sv
// Multicycle RV32 subset control unit: Moore sequencer FETCH/DECODE/EXEC/MEM/WB with
// a sticky TRAP on illegal opcodes or a memory handshake that never completes.
//
// state  | meaning
// FETCH  | read instruction; on mem_ready load IR and PC+4
// DECODE | PC-relative target into ALUOut, pick immediate format
// EXEC   | address / ALU op / branch resolve / jal / lui
// MEM    | data load or store, wait for mem_ready
// WB     | register file write
// TRAP   | illegal instruction or memory timeout, held until reset
module multicycle_control #(
  parameter int ALU_CTRL_W  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            op,
  input  logic [2:0]            func3,
  input  logic [6:0]            func7,
  input  logic                  alu_zero,
  input  logic                  alu_last_bit,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  mem_req,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic                  pc_source,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [2:0]            imm_source,
  output logic [2:0]            state,
  output logic                  illegal,
  output logic                  timeout
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_TRAP   = 3'b101
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9;

  state_t     state_q, state_d;
  logic [7:0] wait_q;
  logic       illegal_q, timeout_q;
  logic       set_illegal, set_timeout;
  logic       wait_hit, op_ok, br_cond;
  logic [3:0] alu_code;
  logic       unused_func7;

  assign unused_func7 = ^{func7[6], func7[4:0]};
  assign state   = state_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign alu_control = ALU_CTRL_W'(alu_code);

  // This cycle would be the TIMEOUT_CYC-th one without a handshake
  assign wait_hit = ({1'b0, wait_q} + 9'd1) == 9'(TIMEOUT_CYC);
  assign op_ok = (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_I) ||
                 (op == OP_BR) || (op == OP_JAL) || (op == OP_LUI);

  // alt selects SUB over ADD for func3 000 and SRA over SRL for func3 101
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    pc_write = 1'b0; ir_write = 1'b0; mem_req = 1'b0; mem_read = 1'b0;
    mem_write = 1'b0; reg_write = 1'b0; pc_source = 1'b0;
    alu_src_a = 2'b00; alu_src_b = 2'b00; result_src = 2'b00;
    imm_source = 3'b000; alu_code = ALU_ADD; br_cond = 1'b0;
    state_d = state_q; set_illegal = 1'b0; set_timeout = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1; mem_read = 1'b1; alu_src_b = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1; pc_write = 1'b1; state_d = S_DECODE;
        end else if (wait_hit) begin
          set_timeout = 1'b1; state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01; alu_src_b = 2'b01;
        case (op)
          OP_SW:   imm_source = 3'b001;
          OP_BR:   imm_source = 3'b010;
          OP_LUI:  imm_source = 3'b011;
          OP_JAL:  imm_source = 3'b100;
          default: imm_source = 3'b000;
        endcase
        if (op_ok) state_d = S_EXEC;
        else begin
          set_illegal = 1'b1; state_d = S_TRAP;
        end
      end
      S_EXEC: begin
        case (op)
          OP_LW, OP_SW: begin
            alu_src_a = 2'b10; alu_src_b = 2'b01; state_d = S_MEM;
          end
          OP_R: begin
            alu_src_a = 2'b10; alu_code = alu_decode(func3, func7[5]); state_d = S_WB;
          end
          OP_I: begin
            alu_src_a = 2'b10; alu_src_b = 2'b01;
            alu_code = alu_decode(func3, (func3 == 3'b101) && func7[5]);
            state_d = S_WB;
          end
          OP_BR: begin
            alu_src_a = 2'b10; state_d = S_FETCH;
            case (func3[2:1])
              2'b00: begin alu_code = ALU_SUB;  br_cond = alu_zero;     end
              2'b10: begin alu_code = ALU_SLT;  br_cond = alu_last_bit; end
              2'b11: begin alu_code = ALU_SLTU; br_cond = alu_last_bit; end
              default: begin set_illegal = 1'b1; state_d = S_TRAP; end
            endcase
            // func3[0] inverts the sense: bne, bge, bgeu
            if ((func3[2:1] != 2'b01) && (br_cond ^ func3[0])) begin
              pc_write = 1'b1; pc_source = 1'b1;
            end
          end
          OP_JAL: begin
            pc_write = 1'b1; pc_source = 1'b1; state_d = S_WB;
          end
          OP_LUI: begin
            alu_src_a = 2'b11; alu_src_b = 2'b01; state_d = S_WB;
          end
          default: begin set_illegal = 1'b1; state_d = S_TRAP; end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        if (op == OP_LW) mem_read = 1'b1;
        else mem_write = 1'b1;
        if (mem_ready) state_d = (op == OP_LW) ? S_WB : S_FETCH;
        else if (wait_hit) begin
          set_timeout = 1'b1; state_d = S_TRAP;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        if (op == OP_LW) result_src = 2'b01;
        else if (op == OP_JAL) result_src = 2'b10;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) || mem_ready) wait_q <= '0;
      else if (mem_req) wait_q <= wait_q + 8'd1;
      illegal_q <= illegal_q | set_illegal;
      timeout_q <= timeout_q | set_timeout;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios with literal checks, then random
// instruction streams compared each cycle against an instruction-level model.
module tb_multicycle_control;
  localparam int TO = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [6:0] op = '0, func7 = '0;
  logic [2:0] func3 = '0;
  logic       alu_zero = 1'b0, alu_last_bit = 1'b0, mem_ready = 1'b0;
  logic       pc_write, ir_write, mem_req, mem_read, mem_write, reg_write, pc_source;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_control;
  logic [2:0] imm_source, state;
  logic       illegal, timeout;

  multicycle_control #(.ALU_CTRL_W(4), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func3(func3), .func7(func7),
    .alu_zero(alu_zero), .alu_last_bit(alu_last_bit), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_req(mem_req), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_control(alu_control), .imm_source(imm_source), .state(state),
    .illegal(illegal), .timeout(timeout));

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc_write, ir_write, mem_req, mem_read, mem_write, reg_write, pc_source;
    logic [1:0] src_a, src_b, rsrc;
    logic [3:0] alu;
    logic [2:0] imm, st;
    logic ill, to;
  } outs_t;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111, LUI = 7'b0110111;

  int n_cmp = 0, n_bad = 0;
  logic [6:0] nxt_op = '0, nxt_f7 = '0;
  logic [2:0] nxt_f3 = '0;
  int m_st = 0, m_wait = 0;
  logic m_ill = 1'b0, m_to = 1'b0;

  int f3_alu[8] = '{0, 7, 5, 6, 4, 8, 3, 2};
  int br_alu[4] = '{1, 0, 5, 6};
  int imm_tab[8] = '{0, 0, 1, 0, 0, 2, 4, 3};
  int lw_seq[5] = '{0, 1, 2, 3, 4};
  logic [6:0] op_tab[7] = '{LW, SW, RT, IT, BR, JAL, LUI};

  // 0 unsupported, 1 lw, 2 sw, 3 R, 4 I-ALU, 5 branch, 6 jal, 7 lui
  function automatic int kind_of(input logic [6:0] o);
    case (o)
      LW: return 1; SW: return 2; RT: return 3; IT: return 4;
      BR: return 5; JAL: return 6; LUI: return 7;
      default: return 0;
    endcase
  endfunction

  function automatic int alu_of(input logic [2:0] f3, input logic b5, input logic is_r);
    if (f3 == 3'b000 && is_r && b5) return 1;
    if (f3 == 3'b101 && b5) return 9;
    return f3_alu[f3];
  endfunction

  function automatic outs_t model_out();
    outs_t o;
    int k;
    logic taken;
    o = '0;
    k = kind_of(op);
    o.st = 3'(m_st); o.ill = m_ill; o.to = m_to;
    case (m_st)
      0: begin
        o.mem_req = 1; o.mem_read = 1; o.src_b = 2;
        if (mem_ready) begin o.ir_write = 1; o.pc_write = 1; end
      end
      1: begin o.src_a = 1; o.src_b = 1; o.imm = 3'(imm_tab[k]); end
      2: begin
        if (k == 1 || k == 2) begin o.src_a = 2; o.src_b = 1; end
        else if (k == 3) begin o.src_a = 2; o.alu = 4'(alu_of(func3, func7[5], 1'b1)); end
        else if (k == 4) begin o.src_a = 2; o.src_b = 1; o.alu = 4'(alu_of(func3, func7[5], 1'b0)); end
        else if (k == 5) begin
          o.src_a = 2;
          o.alu = 4'(br_alu[func3[2:1]]);
          taken = (func3[2] ? alu_last_bit : alu_zero) ^ func3[0];
          if (func3[2:1] != 2'b01 && taken) begin o.pc_write = 1; o.pc_source = 1; end
        end
        else if (k == 6) begin o.pc_write = 1; o.pc_source = 1; end
        else if (k == 7) begin o.src_a = 3; o.src_b = 1; end
      end
      3: begin o.mem_req = 1; o.mem_read = (k == 1); o.mem_write = (k == 2); end
      4: begin o.reg_write = 1; o.rsrc = (k == 1) ? 2'd1 : (k == 6) ? 2'd2 : 2'd0; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic model_step();
    int k, nxt;
    k = kind_of(op);
    nxt = m_st;
    case (m_st)
      0, 3: begin
        if (mem_ready) nxt = (m_st == 0) ? 1 : (k == 1) ? 4 : 0;
        else if (m_wait + 1 == TO) begin nxt = 5; m_to = 1; end
      end
      1: if (k == 0) begin nxt = 5; m_ill = 1; end else nxt = 2;
      2: begin
        if (k == 1 || k == 2) nxt = 3;
        else if (k == 5) begin
          if (func3[2:1] == 2'b01) begin nxt = 5; m_ill = 1; end else nxt = 0;
        end else if (k == 0) begin nxt = 5; m_ill = 1; end
        else nxt = 4;
      end
      4: nxt = 0;
      default: nxt = 5;
    endcase
    if (nxt != m_st || mem_ready) m_wait = 0;
    else if (m_st == 0 || m_st == 3) m_wait++;
    m_st = nxt;
  endtask

  function automatic outs_t dut_out();
    outs_t a;
    a.pc_write = pc_write; a.ir_write = ir_write; a.mem_req = mem_req; a.mem_read = mem_read;
    a.mem_write = mem_write; a.reg_write = reg_write; a.pc_source = pc_source;
    a.src_a = alu_src_a; a.src_b = alu_src_b; a.rsrc = result_src; a.alu = alu_control;
    a.imm = imm_source; a.st = state; a.ill = illegal; a.to = timeout;
    return a;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rdy, input logic z, input logic lb);
    outs_t e, a;
    @(negedge clk);
    op = nxt_op; func3 = nxt_f3; func7 = nxt_f7;
    mem_ready = rdy; alu_zero = z; alu_last_bit = lb;
    #1;
    e = model_out();
    a = dut_out();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL cycle model_state=%0d op=%b f3=%b: got %h expected %h at %0t",
               m_st, op, func3, a, e, $time);
    end
    model_step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; mem_ready = 1'b0;
    #1;
    check("rst_state", int'(state), 0);
    check("rst_mem_req", int'(mem_req), 1);
    check("rst_mem_write", int'(mem_write), 0);
    check("rst_illegal", int'(illegal), 0);
    check("rst_timeout", int'(timeout), 0);
    m_st = 0; m_wait = 0; m_ill = 1'b0; m_to = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    nxt_op = o; nxt_f3 = f3; nxt_f7 = f7;
  endtask

  initial begin
    #3 apply_reset();

    // lw with immediate handshakes
    set_instr(LW, 3'b010, 7'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check("lw_state", int'(state), lw_seq[i]);
      if (i == 4) begin
        check("lw_wb_reg_write", int'(reg_write), 1);
        check("lw_wb_result_src", int'(result_src), 1);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    check("lw_back_fetch", int'(state), 0);

    // beq taken then not taken
    for (int t = 1; t >= 0; t--) begin
      set_instr(BR, 3'b000, 7'd0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'(t), 1'b0);
      check("beq_pc_write", int'(pc_write), t);
      check("beq_pc_source", int'(pc_source), t);
      check("beq_alu_sub", int'(alu_control), 1);
      step(1'b0, 1'b0, 1'b0);
      check("beq_to_fetch", int'(state), 0);
    end

    // R-type SUB and SRL
    set_instr(RT, 3'b000, 7'b0100000);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    check("r_sub_alu", int'(alu_control), 1);
    step(1'b0, 1'b0, 1'b0);
    check("r_wb_result_src", int'(result_src), 0);
    set_instr(RT, 3'b101, 7'd0);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    check("r_srl_alu", int'(alu_control), 8);
    step(1'b0, 1'b0, 1'b0);

    // unsupported opcode traps
    set_instr(7'b1111111, 3'b000, 7'd0);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b1);
    check("ill_state", int'(state), 5);
    check("ill_flag", int'(illegal), 1);
    check("ill_mem_req", int'(mem_req), 0);
    step(1'b1, 1'b0, 1'b0);
    check("ill_sticky", int'(state), 5);
    apply_reset();

    // MEM timeout, then ready on the last allowed cycle
    set_instr(LW, 3'b010, 7'd0);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TO; i++) begin
      step(1'b0, 1'b0, 1'b0);
      check("to_mem_wait", int'(state), 3);
    end
    step(1'b1, 1'b0, 1'b0);
    check("to_trap", int'(state), 5);
    check("to_flag", int'(timeout), 1);
    apply_reset();
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TO - 1; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("ready_wins_wb", int'(state), 4);
    check("ready_wins_no_to", int'(timeout), 0);
    step(1'b0, 1'b0, 1'b0);

    // reset while a store waits in MEM
    set_instr(SW, 3'b010, 7'd0);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("sw_mem_write", int'(mem_write), 1);
    apply_reset();
    for (int i = 0; i < TO - 1; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("post_rst_cnt_clear", int'(state), 1);

    // random instruction stream
    for (int c = 0; c < 4000; c++) begin
      if (m_st == 5 && $urandom_range(0, 3) == 0) apply_reset();
      if (m_st == 0) begin
        nxt_op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : op_tab[$urandom_range(0, 6)];
        nxt_f3 = 3'($urandom);
        nxt_f7 = $urandom_range(0, 1) ? 7'b0100000 :
                 ($urandom_range(0, 1) ? 7'd0 : 7'($urandom));
      end
      step(1'($urandom_range(0, 99) < 75), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
